// File: rtl/enemy_run_anim_ctrl.sv
// enemy_run_anim_ctrl: running-enemy animation sequencer and sprite pixel pipeline.
// Define ENEMY_ANIM_PINGPONG_EN for a back-and-forth frame order instead of wrapping.
module enemy_run_anim_ctrl #(
  parameter int SPR_W      = 24,
  parameter int SPR_H      = 32,
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_HOLD = 6,
  parameter int ADDR_W     = 12,
  parameter int TRANSP_IDX = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              vsync_pulse,
  input  logic              run_en,
  input  logic              dir,
  input  logic [9:0]        enemy_x,
  input  logic [9:0]        enemy_y,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic              pix_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [2:0]        rom_data,
  output logic [2:0]        pal_index,
  output logic              pix_valid,
  output logic              pix_opaque,
  output logic [1:0]        frame_idx
);

  localparam int HOLD_W     = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam int FRAME_AREA = SPR_W * SPR_H;
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(FRAME_HOLD - 1);
  localparam logic [1:0]        FRAME_LAST = 2'(NUM_FRAMES - 1);
  localparam logic signed [10:0] SPR_W_S   = 11'(SPR_W);
  localparam logic signed [10:0] SPR_H_S   = 11'(SPR_H);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } anim_state_t;

  anim_state_t       state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        frame_q, frame_d;
  logic [HOLD_W-1:0] adv_hold;
  logic [1:0]        adv_frame;
`ifdef ENEMY_ANIM_PINGPONG_EN
  logic              down_q, down_d;
  logic              adv_down;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      frame_q <= '0;
`ifdef ENEMY_ANIM_PINGPONG_EN
      down_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      frame_q <= frame_d;
`ifdef ENEMY_ANIM_PINGPONG_EN
      down_q  <= down_d;
`endif
    end
  end

  // One animation step: bump the hold counter, advancing the frame when it expires.
  always_comb begin
    adv_hold  = hold_q + 1'b1;
    adv_frame = frame_q;
`ifdef ENEMY_ANIM_PINGPONG_EN
    adv_down  = down_q;
`endif
    if (hold_q == HOLD_LAST) begin
      adv_hold = '0;
`ifdef ENEMY_ANIM_PINGPONG_EN
      if (NUM_FRAMES == 1) begin
        adv_frame = 2'd0;
      end else if (!down_q) begin
        if (frame_q == FRAME_LAST) begin
          adv_frame = frame_q - 2'd1;
          adv_down  = 1'b1;
        end else begin
          adv_frame = frame_q + 2'd1;
        end
      end else begin
        if (frame_q == 2'd0) begin
          adv_frame = 2'd1;
          adv_down  = 1'b0;
        end else begin
          adv_frame = frame_q - 2'd1;
        end
      end
`else
      if (frame_q == FRAME_LAST) begin
        adv_frame = 2'd0;
      end else begin
        adv_frame = frame_q + 2'd1;
      end
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    frame_d = frame_q;
`ifdef ENEMY_ANIM_PINGPONG_EN
    down_d  = down_q;
`endif
    case (state_q)
      IDLE: begin
        if (vsync_pulse && run_en) begin
          state_d = RUN;
          hold_d  = adv_hold;
          frame_d = adv_frame;
`ifdef ENEMY_ANIM_PINGPONG_EN
          down_d  = adv_down;
`endif
        end
      end
      RUN: begin
        if (vsync_pulse) begin
          if (run_en) begin
            hold_d  = adv_hold;
            frame_d = adv_frame;
`ifdef ENEMY_ANIM_PINGPONG_EN
            down_d  = adv_down;
`endif
          end else begin
            state_d = IDLE;
            hold_d  = '0;
            frame_d = '0;
`ifdef ENEMY_ANIM_PINGPONG_EN
            down_d  = 1'b0;
`endif
          end
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
        frame_d = '0;
`ifdef ENEMY_ANIM_PINGPONG_EN
        down_d  = 1'b0;
`endif
      end
    endcase
  end

  always_comb begin
    frame_idx = frame_q;
  end

  // Pixel stage 0: signed offsets keep left/top misses and right-edge overhang from wrapping.
  logic signed [10:0] dx, dy;
  logic [10:0]        lx;
  logic               hit_s0;
  logic [ADDR_W-1:0]  addr_s0;

  always_comb begin
    dx      = $signed({1'b0, draw_x}) - $signed({1'b0, enemy_x});
    dy      = $signed({1'b0, draw_y}) - $signed({1'b0, enemy_y});
    hit_s0  = !dx[10] && (dx < SPR_W_S) && !dy[10] && (dy < SPR_H_S);
    lx      = dir ? (11'(SPR_W - 1) - dx) : dx;
    addr_s0 = ADDR_W'((32'(frame_q) * 32'(FRAME_AREA)) + (32'(dy) * 32'(SPR_W)) + 32'(lx));
  end

  logic s1_valid, s1_hit;
  logic opaque_s1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr <= '0;
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
    end else begin
      s1_valid <= pix_req;
      s1_hit   <= pix_req && hit_s0;
      if (pix_req && hit_s0) begin
        rom_addr <= addr_s0;
      end
    end
  end

  always_comb begin
    opaque_s1 = s1_hit && (rom_data != 3'(TRANSP_IDX));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_valid  <= 1'b0;
      pix_opaque <= 1'b0;
      pal_index  <= 3'd0;
    end else begin
      pix_valid  <= s1_valid;
      pix_opaque <= opaque_s1;
      pal_index  <= opaque_s1 ? rom_data : 3'd0;
    end
  end

endmodule

// File: tb/tb_enemy_run_anim_ctrl.sv
// tb_enemy_run_anim_ctrl: directed plus randomized check of enemy_run_anim_ctrl against a behavioural model.
// Honours ENEMY_ANIM_PINGPONG_EN so the model matches the build under test.
module tb_enemy_run_anim_ctrl;

  localparam int SPR_W      = 24;
  localparam int SPR_H      = 32;
  localparam int NUM_FRAMES = 4;
  localparam int FRAME_HOLD = 6;
  localparam int ADDR_W     = 12;
  localparam int TRANSP_IDX = 1;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              vsync_pulse = 1'b0;
  logic              run_en = 1'b0;
  logic              dir = 1'b0;
  logic [9:0]        enemy_x = '0;
  logic [9:0]        enemy_y = '0;
  logic [9:0]        draw_x = '0;
  logic [9:0]        draw_y = '0;
  logic              pix_req = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [2:0]        rom_data;
  logic [2:0]        pal_index;
  logic              pix_valid;
  logic              pix_opaque;
  logic [1:0]        frame_idx;

  int total = 0;
  int bad = 0;

  enemy_run_anim_ctrl #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(NUM_FRAMES),
    .FRAME_HOLD(FRAME_HOLD), .ADDR_W(ADDR_W), .TRANSP_IDX(TRANSP_IDX)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .vsync_pulse(vsync_pulse), .run_en(run_en),
    .dir(dir), .enemy_x(enemy_x), .enemy_y(enemy_y), .draw_x(draw_x),
    .draw_y(draw_y), .pix_req(pix_req), .rom_addr(rom_addr), .rom_data(rom_data),
    .pal_index(pal_index), .pix_valid(pix_valid), .pix_opaque(pix_opaque),
    .frame_idx(frame_idx)
  );

  always #5 Clk = ~Clk;

  // Sprite ROM stand-in: contents are a scramble of the address so a wrong address shows up in pal_index.
  function automatic logic [2:0] romf(input logic [ADDR_W-1:0] a);
    return a[2:0] ^ a[5:3] ^ a[8:6];
  endfunction

  assign rom_data = romf(rom_addr);

  int                run_cnt;
  logic [ADDR_W-1:0] m_addr;
  bit                e1_valid, e1_hit, e2_valid, e2_opq;
  logic [2:0]        e1_data, e2_pal;

  // Displayed frame as a function of how many strobes have been seen since running began.
  function automatic int modelFrame(input int cnt);
    int step;
    step = cnt / FRAME_HOLD;
`ifdef ENEMY_ANIM_PINGPONG_EN
    if (NUM_FRAMES == 1) return 0;
    begin
      int period, p;
      period = 2 * (NUM_FRAMES - 1);
      p = step % period;
      return (p < NUM_FRAMES) ? p : period - p;
    end
`else
    return step % NUM_FRAMES;
`endif
  endfunction

  task automatic resetModel();
    run_cnt  = 0;
    m_addr   = '0;
    e1_valid = 0; e1_hit = 0; e1_data = 3'd0;
    e2_valid = 0; e2_opq = 0; e2_pal = 3'd0;
  endtask

  task automatic modelClock();
    int f, ddx, ddy, lx;
    bit hit;
    f = modelFrame(run_cnt);
    e2_valid = e1_valid;
    e2_opq   = e1_hit && (int'(e1_data) != TRANSP_IDX);
    e2_pal   = e2_opq ? e1_data : 3'd0;
    ddx = int'(draw_x) - int'(enemy_x);
    ddy = int'(draw_y) - int'(enemy_y);
    hit = pix_req && ddx >= 0 && ddx < SPR_W && ddy >= 0 && ddy < SPR_H;
    if (hit) begin
      lx = dir ? (SPR_W - 1 - ddx) : ddx;
      m_addr = ADDR_W'(f * SPR_W * SPR_H + ddy * SPR_W + lx);
    end
    e1_valid = pix_req;
    e1_hit   = hit;
    e1_data  = romf(m_addr);
    if (vsync_pulse) run_cnt = run_en ? run_cnt + 1 : 0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("frame_idx", 32'(frame_idx), 32'(modelFrame(run_cnt)));
    checkOutput("rom_addr", 32'(rom_addr), 32'(m_addr));
    checkOutput("pix_valid", 32'(pix_valid), 32'(e2_valid));
    checkOutput("pix_opaque", 32'(pix_opaque), 32'(e2_opq));
    checkOutput("pal_index", 32'(pal_index), 32'(e2_pal));
  endtask

  task automatic stepCycle();
    @(posedge Clk);
    modelClock();
    @(negedge Clk);
    checkAll();
  endtask

  // Asserts reset right now (between edges), so any in-flight pixels must vanish.
  task automatic doReset();
    Reset_n = 1'b0;
    resetModel();
    #1;
    checkAll();
    @(negedge Clk);
    checkAll();
    Reset_n = 1'b1;
  endtask

  task automatic applyStimulus();
    int pick;
    if ($urandom_range(0, 39) == 0) run_en = ~run_en;
    vsync_pulse = ($urandom_range(0, 4) == 0);
    pix_req     = ($urandom_range(0, 3) != 0);
    dir         = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 15) == 0) begin
      pick = int'($urandom_range(0, 2));
      enemy_x = (pick == 0) ? 10'd0 : (pick == 1) ? 10'd630 : 10'($urandom_range(0, 639));
      enemy_y = 10'($urandom_range(0, 479));
    end
    if ($urandom_range(0, 9) == 0) begin
      draw_x = 10'($urandom);
      draw_y = 10'($urandom);
    end else begin
      draw_x = 10'(int'(enemy_x) + int'($urandom_range(0, SPR_W + 8)) - 4);
      draw_y = 10'(int'(enemy_y) + int'($urandom_range(0, SPR_H + 8)) - 4);
    end
    stepCycle();
  endtask

  initial begin
    resetModel();
    doReset();

    run_en = 1'b1; enemy_x = 10'd100; enemy_y = 10'd50; dir = 1'b0;
    draw_x = 10'd101; draw_y = 10'd52; pix_req = 1'b1;
    stepCycle();
    checkOutput("addr_dir0", 32'(rom_addr), 32'd49);
    pix_req = 1'b0;
    stepCycle();
    checkOutput("valid_lat2", 32'(pix_valid), 32'd1);
    dir = 1'b1; pix_req = 1'b1;
    stepCycle();
    checkOutput("addr_dir1", 32'(rom_addr), 32'd70);
    pix_req = 1'b0;

    for (int i = 0; i < 6; i++) begin
      vsync_pulse = 1'b1;
      stepCycle();
      vsync_pulse = 1'b0;
      stepCycle();
    end
    checkOutput("frame_after6", 32'(frame_idx), 32'd1);
    pix_req = 1'b1;
    stepCycle();
    checkOutput("addr_frame1", 32'(rom_addr), 32'd838);
    pix_req = 1'b0;

    enemy_x = 10'd630; draw_x = 10'd629; draw_y = 10'd52; dir = 1'b0; pix_req = 1'b1;
    stepCycle();
    draw_x = 10'd639;
    stepCycle();
    draw_x = 10'd0; enemy_x = 10'd0;
    stepCycle();
    draw_x = 10'd24;
    stepCycle();
    pix_req = 1'b0;
    stepCycle();
    stepCycle();

    run_en = 1'b0; vsync_pulse = 1'b1;
    stepCycle();
    checkOutput("frame_stop", 32'(frame_idx), 32'd0);
    vsync_pulse = 1'b0;
    stepCycle();
    run_en = 1'b1;

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 699) == 0) begin
        pix_req = 1'b1;
        doReset();
      end else begin
        applyStimulus();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/enemy_run_anim_ctrl.md
Name: enemy_run_anim_ctrl

Overview:
- Sequencer for one running-enemy sprite: advances the animation frame on vertical-sync strobes and converts each VGA draw coordinate into a sprite-ROM address.
- Takes the 3-bit colour index returned by the sprite ROM and presents it to the enemy palette LUT, with hit and transparency qualification.
- Sits between the VGA controller / sprite ROM and the palette-to-colour mapper in the enemy draw path.

Parameters:
- SPR_W, 24, sprite width in pixels
- SPR_H, 32, sprite height in pixels
- NUM_FRAMES, 4, animation frames stored consecutively in ROM
- FRAME_HOLD, 6, vsync strobes each frame is displayed
- ADDR_W, 12, ROM address width; must be ≥ clog2(NUM_FRAMES*SPR_W*SPR_H)
- TRANSP_IDX, 1, palette index treated as transparent

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- vsync_pulse  in  1  one-cycle strobe at start of vertical blank
- run_en  in  1  enemy is running (animate); 0 = standing pose
- dir  in  1  0 = face left (ROM orientation), 1 = face right (horizontal mirror)
- enemy_x  in  10  sprite top-left X
- enemy_y  in  10  sprite top-left Y
- draw_x  in  10  current pixel X
- draw_y  in  10  current pixel Y
- pix_req  in  1  draw_x/draw_y valid this cycle
- rom_addr  out  ADDR_W  sprite ROM address; synchronous ROM, 1-cycle read latency
- rom_data  in  3  ROM colour index
- pal_index  out  3  index to palette LUT
- pix_valid  out  1  pal_index/pix_opaque valid
- pix_opaque  out  1  pixel inside sprite and not transparent
- frame_idx  out  2  frame currently displayed

Behaviour:
- Reset: all outputs and internal state go to 0. Animation FSM enters IDLE.
- Animation FSM:
  - IDLE: frame 0, hold counter 0.
  - IDLE→RUN on a vsync_pulse with run_en=1.
  - RUN: each vsync_pulse increments the hold counter. On the strobe where the counter equals FRAME_HOLD-1, the counter clears and the frame advances; NUM_FRAMES-1 wraps to 0.
  - RUN→IDLE on a vsync_pulse with run_en=0; frame forced to 0.
  - run_en is sampled only on vsync_pulse.
- frame_idx changes only in the cycle after a vsync_pulse, so there is no mid-frame tearing.
- Pixel pipeline, 2-cycle latency from pix_req to pix_valid; fully pipelined, accepts one request per cycle.
  - S0, registered into S1:
    - hit = draw_x−enemy_x in [0,SPR_W) and draw_y−enemy_y in [0,SPR_H). Compute in 11-bit signed so negatives and 639+SPR_W do not wrap.
    - lx = dir ? SPR_W−1−dx : dx; ly = dy.
    - rom_addr = frame_idx*SPR_W*SPR_H + ly*SPR_W + lx, truncated to ADDR_W.
    - rom_addr is held at last value when pix_req=0 or miss.
    - S1 stores valid and hit.
  - S2, registered:
    - pix_valid = S1 valid.
    - pix_opaque = S1 hit && rom_data≠TRANSP_IDX.
    - pal_index = pix_opaque ? rom_data : 0.
- A pix_req coincident with vsync_pulse uses the pre-update frame_idx.
- Reset_n asserted mid-pipeline clears in-flight pixels; no pix_valid is produced for them.

Optional Feature:
- ENEMY_ANIM_PINGPONG_EN
  - Defined: RUN sequence is 0,1,…,NUM_FRAMES−1,NUM_FRAMES−2,…,1,0,1…, using an internal direction bit cleared on reset and on entry to IDLE. With NUM_FRAMES=1 the frame stays at 0.
  - Undefined: wrap sequence as above; no direction bit is present.

Test Plan:
- Reset, run_en=1, 6 vsync_pulses → frame_idx 0→1 one cycle after the 6th strobe. 24 strobes → back to 0.
- run_en=0 at strobe during frame 2 → frame_idx=0 next cycle; FSM IDLE; further strobes leave it at 0.
- enemy_x=100, enemy_y=50, dir=0, frame 0, pix_req at (101,52) → rom_addr=49 next cycle. Two cycles after the request: pix_valid=1, pal_index=rom_data. With rom_data=1: pix_opaque=0, pal_index=0.
- Same setup with dir=1 → rom_addr=2*24+22=70. Frame 1 → rom_addr=768+70=838.
- Edges with enemy_x=630: draw_x=629 → miss; draw_x=639 → hit, dx=9. With enemy_x=0, draw_x=0 → hit; draw_x=24 → miss.
- PINGPONG build, FRAME_HOLD=1, 8 strobes → frame_idx 1,2,3,2,1,0,1,2.
